// File: rtl/tank_sensor_model_pkg.sv
// Shared encodings and defaults for the tank model and the level-decoder bench.
// Sensor vectors are ordered {H, M, L}, so a fault select code doubles as the bit index.
package tank_sensor_model_pkg;

  typedef enum logic [1:0] {
    FAULT_SEL_L    = 2'b00,
    FAULT_SEL_M    = 2'b01,
    FAULT_SEL_H    = 2'b10,
    FAULT_SEL_NONE = 2'b11
  } fault_sel_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } fault_state_t;

  localparam int DEF_TH_L = 64;
  localparam int DEF_TH_M = 128;
  localparam int DEF_TH_H = 192;

  // Force one sensor bit to val while a fault is active; NONE leaves raw untouched.
  function automatic logic [2:0] apply_fault(input logic [2:0] raw, input logic active,
                                             input fault_sel_t sel, input logic val);
    logic [2:0] res;
    res = raw;
    if (active) begin
      case (sel)
        FAULT_SEL_L: res[0] = val;
        FAULT_SEL_M: res[1] = val;
        FAULT_SEL_H: res[2] = val;
        default:     res = raw;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/tank_sensor_model_if.sv
// Valve controls, fault injection and modelled sensor/level outputs of the tank model.
interface tank_sensor_model_if #(
  parameter int LEVEL_W = 8
);
  logic               Ve;
  logic               Vs;
  logic               fault_en;
  logic [1:0]         fault_sel;
  logic               fault_val;
  logic               H;
  logic               M;
  logic               L;
  logic [LEVEL_W-1:0] level;
  logic               tick;
  logic               overflow;
  logic               dry;

  modport master (
    output Ve, Vs, fault_en, fault_sel, fault_val,
    input  H, M, L, level, tick, overflow, dry
  );

  modport slave (
    input  Ve, Vs, fault_en, fault_sel, fault_val,
    output H, M, L, level, tick, overflow, dry
  );
endinterface

// File: rtl/tank_sensor_model_tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick is high during the terminal count cycle.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/tank_sensor_model.sv
// Behavioural water tank: integrates Ve/Vs into a saturating level and produces
// thermometer-coded H/M/L sensor outputs with optional single-sensor fault forcing.
module tank_sensor_model
  import tank_sensor_model_pkg::*;
#(
  parameter int LEVEL_W    = 8,
  parameter int LEVEL_MAX  = 255,
  parameter int INIT_LEVEL = 0,
  parameter int TH_L       = DEF_TH_L,
  parameter int TH_M       = DEF_TH_M,
  parameter int TH_H       = DEF_TH_H,
  parameter int PRESCALE   = 50000,
  parameter int FILL_STEP  = 2,
  parameter int DRAIN_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  tank_sensor_model_if.slave   bus
);
  localparam int DW = LEVEL_W + 2;
  localparam logic signed [DW-1:0] MAX_S = DW'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] MAX_V   = LEVEL_W'(LEVEL_MAX);
  localparam int TH [3] = '{TH_L, TH_M, TH_H};
  localparam logic [2:0] INIT_HML = {1'(INIT_LEVEL >= TH_H), 1'(INIT_LEVEL >= TH_M),
                                     1'(INIT_LEVEL >= TH_L)};

  logic                  tick;
  logic [LEVEL_W-1:0]    level_reg, level_next;
  logic                  overflow_reg, dry_reg;
  logic signed [DW-1:0]  delta, sum;
  logic [2:0]            raw_hml, hml_reg, hml_next;
  fault_state_t          state_reg;
  fault_sel_t            sel_reg, sel_eff;
  logic                  val_reg, val_eff;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Signed net flow; two spare bits keep level+delta free of wrap before clamping.
  always_comb begin
    delta = (bus.Ve ? DW'(FILL_STEP) : '0) - (bus.Vs ? DW'(DRAIN_STEP) : '0);
    sum   = $signed({2'b00, level_reg}) + delta;
    if (sum < 0) begin
      level_next = '0;
    end else if (sum > MAX_S) begin
      level_next = MAX_V;
    end else begin
      level_next = sum[LEVEL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_reg    <= LEVEL_W'(INIT_LEVEL);
      overflow_reg <= 1'b0;
      dry_reg      <= 1'b0;
    end else if (tick) begin
      level_reg <= level_next;
      if (bus.Ve && (delta > 0) && (level_reg == MAX_V)) overflow_reg <= 1'b1;
      if (bus.Vs && (delta < 0) && (level_reg == '0))    dry_reg      <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sense
    assign raw_hml[gi] = (level_reg >= LEVEL_W'(TH[gi]));
  end

  // The capture happening on this edge must already steer the override, hence the bypass.
  assign sel_eff  = (state_reg == ST_NORMAL) ? fault_sel_t'(bus.fault_sel) : sel_reg;
  assign val_eff  = (state_reg == ST_NORMAL) ? bus.fault_val : val_reg;
  assign hml_next = apply_fault(raw_hml, bus.fault_en, sel_eff, val_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_NORMAL;
      sel_reg   <= FAULT_SEL_NONE;
      val_reg   <= 1'b0;
      hml_reg   <= INIT_HML;
    end else begin
      case (state_reg)
        ST_NORMAL: begin
          if (bus.fault_en) begin
            state_reg <= ST_FAULT;
            sel_reg   <= fault_sel_t'(bus.fault_sel);
            val_reg   <= bus.fault_val;
          end
        end
        default: begin
          if (!bus.fault_en) state_reg <= ST_NORMAL;
        end
      endcase
      hml_reg <= hml_next;
    end
  end

  assign {bus.H, bus.M, bus.L} = hml_reg;
  assign bus.level    = level_reg;
  assign bus.tick     = tick;
  assign bus.overflow = overflow_reg;
  assign bus.dry      = dry_reg;
endmodule
